mem_stage: RTL

- Memory-access stage of the 5-stage RV32I pipeline. Consumes the EX/MEM latch outputs (which carry the result of the EX stage fed by the ID/EX register) and produces writeback fields for the MEM/WB latch.
- Loads and stores run byte-serially over the shared 8-bit memory-controller port.
- Holds the pipeline through stall_req_mem while an access is in flight.

---
 rtl/mem_stage_pkg.sv | 40 ++++
 rtl/mem_ld_ext.sv | 21 ++
 rtl/mem_stage.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared opcode bus constants, opcode helpers and MEM-stage state encoding.
package mem_stage_pkg;

    localparam int          OPT_BUS_W = 6;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef logic [OPT_BUS_W-1:0] opt_t;

    localparam opt_t OP_NOP = 6'd0;
    localparam opt_t OP_LB  = 6'd1;
    localparam opt_t OP_LH  = 6'd2;
    localparam opt_t OP_LW  = 6'd3;
    localparam opt_t OP_LBU = 6'd4;
    localparam opt_t OP_LHU = 6'd5;
    localparam opt_t OP_SB  = 6'd6;
    localparam opt_t OP_SH  = 6'd7;
    localparam opt_t OP_SW  = 6'd8;
    localparam opt_t OP_ADD = 6'd9;

    typedef enum logic [1:0] {S_IDLE, S_LD_WAIT, S_ST, S_DONE} state_e;

    function automatic logic [2:0] op_bytes(input opt_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_bytes = 3'd1;
            OP_LH, OP_LHU, OP_SH: op_bytes = 3'd2;
            OP_LW, OP_SW:         op_bytes = 3'd4;
            default:              op_bytes = 3'd0;
        endcase
    endfunction

    function automatic logic is_load(input opt_t op);
        is_load = (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
                  (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_store(input opt_t op);
        is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_ld_ext.sv
// Size and sign/zero extension of the little-endian word assembled from load bytes.
module mem_ld_ext
    import mem_stage_pkg::*;
(
    input  opt_t        inst_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = word_i;
        case (inst_i)
            OP_LB:   data_o = {{24{word_i[7]}}, word_i[7:0]};
            OP_LBU:  data_o = {24'h0, word_i[7:0]};
            OP_LH:   data_o = {{16{word_i[15]}}, word_i[15:0]};
            OP_LHU:  data_o = {16'h0, word_i[15:0]};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: byte-serial loads/stores over an 8-bit controller port.
// MEM_ALIGN_CHECK_EN: misaligned halfword/word accesses complete without a request and flag misalign_err.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int OPT_W  = OPT_BUS_W,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [OPT_W-1:0]  in_inst,
    input  logic [4:0]        in_rd,
    input  logic              in_w_enable,
    input  logic [31:0]       in_alu,
    input  logic [31:0]       in_vs2,
    input  logic              mc_gnt,
    input  logic              mc_rvalid,
    input  logic [7:0]        mc_rdata,
    output logic              mc_req,
    output logic              mc_wr,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [7:0]        mc_wdata,
    output logic              stall_req_mem,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              wb_w_enable,
    output logic              misalign_err
);

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] asm_q, asm_d;
    logic        pend_q, pend_d;
    logic        mis_q, mis_launch;

    opt_t              op;
    logic [2:0]        n_bytes;
    logic              op_ld, op_st, op_mem;
    logic [1:0]        ld_pos;
    logic [ADDR_W-1:0] byte_addr;
    logic [31:0]       ld_data;

    assign op        = opt_t'(in_inst);
    assign n_bytes   = op_bytes(op);
    assign op_ld     = is_load(op);
    assign op_st     = is_store(op);
    assign op_mem    = op_ld | op_st;
    assign ld_pos    = 2'(idx_q - 3'd1);
    assign byte_addr = in_alu[ADDR_W-1:0] + ADDR_W'(idx_q);

`ifdef MEM_ALIGN_CHECK_EN
    assign mis_launch = ((n_bytes == 3'd2) && in_alu[0]) ||
                        ((n_bytes == 3'd4) && (in_alu[1:0] != 2'b00));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     mis_q <= 1'b0;
        else if (rdy) mis_q <= (state_q == S_IDLE) && op_mem && mis_launch;
    end
`else
    assign mis_launch = 1'b0;
    assign mis_q      = 1'b0;
`endif

    mem_ld_ext u_ld_ext (
        .inst_i (op),
        .word_i (asm_q),
        .data_o (ld_data)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        asm_d         = asm_q;
        pend_d        = pend_q;
        mc_req        = 1'b0;
        mc_wr         = 1'b0;
        mc_addr       = '0;
        mc_wdata      = 8'h00;
        stall_req_mem = 1'b0;
        wb_rd         = in_rd;
        wb_data       = in_alu;
        wb_w_enable   = in_w_enable;
        misalign_err  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (op_mem) begin
                    stall_req_mem = 1'b1;
                    wb_w_enable   = 1'b0;
                    if (mis_launch) begin
                        state_d = S_DONE;
                    end else begin
                        mc_req   = 1'b1;
                        mc_wr    = op_st;
                        mc_addr  = in_alu[ADDR_W-1:0];
                        mc_wdata = in_vs2[7:0];
                        asm_d    = ZERO_WORD;
                        pend_d   = 1'b0;
                        if (mc_gnt) begin
                            idx_d = 3'd1;
                            if (op_ld)                  state_d = S_LD_WAIT;
                            else if (n_bytes == 3'd1)   state_d = S_DONE;
                            else                        state_d = S_ST;
                        end
                    end
                end
            end
            S_ST: begin
                stall_req_mem = 1'b1;
                wb_w_enable   = 1'b0;
                mc_req        = 1'b1;
                mc_wr         = 1'b1;
                mc_addr       = byte_addr;
                mc_wdata      = in_vs2[{idx_q[1:0], 3'b000} +: 8];
                if (mc_gnt) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q + 3'd1 == n_bytes) state_d = S_DONE;
                end
            end
            S_LD_WAIT: begin
                stall_req_mem = 1'b1;
                wb_w_enable   = 1'b0;
                // pend_q: a follow-on read was offered but not yet granted
                if (pend_q) begin
                    mc_req  = 1'b1;
                    mc_addr = byte_addr;
                    if (mc_gnt) begin
                        idx_d  = idx_q + 3'd1;
                        pend_d = 1'b0;
                    end
                end else if (mc_rvalid) begin
                    asm_d[{ld_pos, 3'b000} +: 8] = mc_rdata;
                    if (idx_q == n_bytes) begin
                        state_d = S_DONE;
                    end else begin
                        mc_req  = 1'b1;
                        mc_addr = byte_addr;
                        if (mc_gnt) idx_d  = idx_q + 3'd1;
                        else        pend_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = 3'd0;
                pend_d  = 1'b0;
                if (op_ld) wb_data = ld_data;
                if (op_st || mis_q) wb_w_enable = 1'b0;
                misalign_err = mis_q;
            end
            default: state_d = S_IDLE;
        endcase

        if (!rdy) mc_req = 1'b0;

        if (!rst) begin
            mc_req        = 1'b0;
            mc_wr         = 1'b0;
            mc_addr       = '0;
            mc_wdata      = 8'h00;
            stall_req_mem = 1'b0;
            wb_rd         = 5'd0;
            wb_data       = ZERO_WORD;
            wb_w_enable   = 1'b0;
            misalign_err  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            asm_q   <= ZERO_WORD;
            pend_q  <= 1'b0;
        end else if (rdy) begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            pend_q  <= pend_d;
        end
    end

endmodule
